muldiv_seq: RTL and testbench

Sequential multiply/divide responder for the ALU operation interface. It accepts the multiply (3'b011) and divide (3'b100) alu_ctrl codes from the control unit, computes the result iteratively over WIDTH cycles, and returns a 64-bit product or quotient/remainder pair in HI/LO with a start/busy/done handshake. The processor uses it to stall on mul/div instead of paying for combinational array logic on the single-cycle critical path.

---
 rtl/muldiv_seq_pkg.sv | 30 +++
 rtl/muldiv_seq_if.sv | 32 +++
 rtl/muldiv_seq_step.sv | 53 +++++
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : shared ALU definitions for the mul/div responder.
//   - alu_ctrl operation encodings driven by the control unit
//   - FSM state encoding of muldiv_seq
//   - datapath mode selector of muldiv_step
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_DIV = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if : request/response bundle between the control unit and the
// sequential multiply/divide responder.
//   master : drives start, alu_ctrl, a, b; observes the response
//   slave  : observes the request; drives busy, done, hi, lo, result, zero,
//            div_by_zero
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, hi, lo, result, zero, div_by_zero
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, hi, lo, result, zero, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq_step.sv
// -----------------------------------------------------------------------------
// muldiv_step : combinational single iteration of the mul/div datapath.
//   i_mode    : MODE_MUL (shift-add) or MODE_DIV (restoring divide)
//   i_acc     : MUL - 2W-bit accumulator; DIV - partial remainder in [W:0]
//   i_bit     : MUL - current multiplier LSB; DIV - next dividend MSB
//   i_operand : MUL - multiplicand; DIV - divisor
//   o_acc     : next accumulator / partial remainder
//   o_qbit    : quotient bit produced by this divide iteration (0 for MUL)
// -----------------------------------------------------------------------------
module muldiv_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mode_t                i_mode,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic                 i_bit,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic                 o_qbit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;

  always_comb begin
    // Upper half plus multiplicand, with the carry kept in bit W.
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    // Remainder always stays below the divisor, so its low W bits suffice.
    w_shift = {i_acc[WIDTH-1:0], i_bit};
    // One extra bit so the sign of the trial subtraction is explicit.
    w_diff  = {1'b0, w_shift} - {2'b00, i_operand};

    o_acc  = '0;
    o_qbit = 1'b0;
    if (i_mode == MODE_MUL) begin
      if (i_bit) begin
        o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1:1]};
      end
    end else begin
      o_qbit = ~w_diff[WIDTH+1];
      if (o_qbit) begin
        o_acc = {{(WIDTH-1){1'b0}}, w_diff[WIDTH:0]};
      end else begin
        o_acc = {{(WIDTH-1){1'b0}}, w_shift};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq : sequential unsigned multiply / divide responder.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : muldiv_seq_if.slave
//           start/alu_ctrl/a/b request; busy, done (1-cycle pulse),
//           hi/lo (product or remainder/quotient), result (= lo),
//           zero (lo == 0), div_by_zero
// MUL/DIV iterate WIDTH cycles; a divide by zero completes on the next edge.
// -----------------------------------------------------------------------------
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_next_state;

  logic [2*WIDTH-1:0] r_acc;      // accumulator / partial remainder
  logic [WIDTH-1:0]   r_mq;       // shifting multiplier / dividend->quotient
  logic [WIDTH-1:0]   r_op;       // multiplicand / divisor
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_zero;
  logic               r_dbz;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_accept;
  logic               w_div0;
  logic               w_iter;
  logic               w_last;
  mode_t              w_mode;
  logic               w_bit;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_mq_nxt;

  always_comb begin
    w_is_mul = (bus.alu_ctrl == ALU_MUL);
    w_is_div = (bus.alu_ctrl == ALU_DIV);
    w_accept = bus.start && (w_is_mul || w_is_div) &&
               ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_div0   = w_is_div && (bus.b == '0);
    w_iter   = (r_state == ST_MUL) || (r_state == ST_DIV);
    w_last   = w_iter && (r_cnt == CW'(WIDTH - 1));
    w_mode   = (r_state == ST_DIV) ? MODE_DIV : MODE_MUL;
    w_bit    = (r_state == ST_DIV) ? r_mq[WIDTH-1] : r_mq[0];
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode    (w_mode),
    .i_acc     (r_acc),
    .i_bit     (w_bit),
    .i_operand (r_op),
    .o_acc     (w_acc_nxt),
    .o_qbit    (w_qbit)
  );

  always_comb begin
    if (r_state == ST_DIV) begin
      w_mq_nxt = {r_mq[WIDTH-2:0], w_qbit};
    end else begin
      w_mq_nxt = r_mq >> 1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          if (w_div0) begin
            w_next_state = ST_DONE;
          end else if (w_is_mul) begin
            w_next_state = ST_MUL;
          end else begin
            w_next_state = ST_DIV;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy        = (r_state == ST_MUL) || (r_state == ST_DIV);
    bus.done        = (r_state == ST_DONE);
    bus.hi          = r_hi;
    bus.lo          = r_lo;
    bus.result      = r_lo;
    bus.zero        = r_zero;
    bus.div_by_zero = r_dbz;
  end

  // Datapath: working registers iterate; hi/lo only load on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_mq   <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_zero <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
      if (w_is_mul) begin
        r_mq <= bus.b;
        r_op <= bus.a;
      end else begin
        r_mq <= bus.a;
        r_op <= bus.b;
      end
      if (w_div0) begin
        r_hi   <= bus.a;
        r_lo   <= '1;
        r_zero <= 1'b0;
        r_dbz  <= 1'b1;
      end
    end else if (w_iter) begin
      r_acc <= w_acc_nxt;
      r_mq  <= w_mq_nxt;
      if (w_last) begin
        if (r_state == ST_MUL) begin
          r_hi   <= w_acc_nxt[2*WIDTH-1:WIDTH];
          r_lo   <= w_acc_nxt[WIDTH-1:0];
          r_zero <= (w_acc_nxt[WIDTH-1:0] == '0);
        end else begin
          r_hi   <= w_acc_nxt[WIDTH-1:0];
          r_lo   <= w_mq_nxt;
          r_zero <= (w_mq_nxt == '0);
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq : scoreboard bench for muldiv_seq. Stimulus pushes the
// arithmetic expectation of every accepted request; a negedge monitor pops
// and compares whenever done is presented.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         dbz;
    int           lat;
    int           e0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus_if ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic exp_t model(input logic [2:0] ctrl, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int e0);
    exp_t e;
    logic [2*W-1:0] p;
    e.e0  = e0;
    e.dbz = 1'b0;
    e.lat = W + 1;
    if (ctrl == ALU_MUL) begin
      p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (b == 0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
    end
    e.zero = (e.lo == 0);
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (bus_if.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, required no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi",          64'(bus_if.hi),          64'(e.hi));
        chk("lo",          64'(bus_if.lo),          64'(e.lo));
        chk("result",      64'(bus_if.result),      64'(e.lo));
        chk("zero",        64'(bus_if.zero),        64'(e.zero));
        chk("div_by_zero", 64'(bus_if.div_by_zero), 64'(e.dbz));
        chk("latency",     64'(cyc - e.e0 + 1),     64'(e.lat));
        chk("busy_at_done", 64'(bus_if.busy),       64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the sampling edge.
  task automatic drive(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_if.start    = 1'b1;
    bus_if.alu_ctrl = ctrl;
    bus_if.a        = a;
    bus_if.b        = b;
    @(negedge clk);
    bus_if.start    = 1'b0;
  endtask

  task automatic issue(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(ctrl, a, b, cyc + 1));
    drive(ctrl, a, b);
  endtask

  // Returns at the negedge of the done cycle; exp_busy < 0 skips the busy count.
  task automatic wait_done(input int exp_busy);
    int n_busy = 0;
    int k = 0;
    while (!bus_if.done && k < 3 * W) begin
      if (bus_if.busy) n_busy++;
      @(negedge clk);
      k++;
    end
    if (!bus_if.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", k);
    end else if (exp_busy >= 0) begin
      chk("busy_cycles", 64'(n_busy), 64'(exp_busy));
    end
  endtask

  initial begin
    logic [2:0]   ctrl;
    logic [W-1:0] ra, rb;
    bit           b2b;

    bus_if.start    = 1'b0;
    bus_if.alu_ctrl = ALU_ADD;
    bus_if.a        = '0;
    bus_if.b        = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(bus_if.busy),        64'd0);
    chk("rst_done",   64'(bus_if.done),        64'd0);
    chk("rst_hi",     64'(bus_if.hi),          64'd0);
    chk("rst_lo",     64'(bus_if.lo),          64'd0);
    chk("rst_result", 64'(bus_if.result),      64'd0);
    chk("rst_zero",   64'(bus_if.zero),        64'd0);
    chk("rst_dbz",    64'(bus_if.div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(ALU_MUL, 32'd7, 32'd6);                 wait_done(W); @(negedge clk);
    issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(W); @(negedge clk);
    issue(ALU_MUL, 32'd0, 32'd5);                 wait_done(W); @(negedge clk);
    issue(ALU_DIV, 32'd100, 32'd7);               wait_done(W); @(negedge clk);
    issue(ALU_DIV, 32'd5, 32'd9);                 wait_done(W); @(negedge clk);
    issue(ALU_DIV, 32'd123, 32'd0);               wait_done(0); @(negedge clk);
    issue(ALU_MUL, 32'd3, 32'd4);
    chk("dbz_cleared", 64'(bus_if.div_by_zero), 64'd0);
    wait_done(-1); @(negedge clk);

    // Non mul/div code is ignored
    drive(ALU_ADD, 32'd1, 32'd2);
    repeat (3) begin
      chk("ignored_busy", 64'(bus_if.busy), 64'd0);
      @(negedge clk);
    end

    // Request mid-multiply is ignored
    issue(ALU_MUL, 32'h1234_5678, 32'h9ABC);
    repeat (4) @(negedge clk);
    drive(ALU_DIV, 32'hDEAD_BEEF, 32'd3);
    wait_done(-1); @(negedge clk);

    // Back-to-back issue in the done cycle
    issue(ALU_MUL, 32'd1000, 32'd1000); wait_done(W);
    issue(ALU_DIV, 32'hFFFF_FFFF, 32'd10); wait_done(W); @(negedge clk);

    // Reset mid-divide aborts with no done
    issue(ALU_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("abort_busy", 64'(bus_if.busy), 64'd0);
    chk("abort_done", 64'(bus_if.done), 64'd0);
    chk("abort_hi",   64'(bus_if.hi),   64'd0);
    chk("abort_lo",   64'(bus_if.lo),   64'd0);
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);

    // Randomized stream
    b2b = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      ctrl = ($urandom_range(1) == 0) ? ALU_MUL : ALU_DIV;
      ra   = ($urandom_range(3) == 0) ? W'($urandom_range(255)) : W'($urandom);
      case ($urandom_range(7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(15));
        default: rb = W'($urandom);
      endcase
      if (!b2b) @(negedge clk);
      issue(ctrl, ra, rb);
      if (!(ctrl == ALU_DIV && rb == 0) && $urandom_range(3) == 0) begin
        @(negedge clk);
        drive(($urandom_range(1) == 0) ? ALU_MUL : ALU_DIV, W'($urandom), W'($urandom));
      end
      wait_done(-1);
      b2b = ($urandom_range(2) == 0);
    end
    repeat (W + 5) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
